ysyx_041461_if_fetch: RTL and testbench
=======================================

// Module: ysyx_041461_if_fetch
// PURPOSE
//  Instruction-fetch engine. Consumes the PC held by the PC register, issues one
//  AXI4-Lite-style read per PC and returns the 32-bit instruction to ID.
//  Generates the PC-register enable: PC advances or redirects only when this block allows.
//  Single outstanding request; drops stale responses on redirect.
// PARAMETERS
//  ADDR_W   32  width of bus read address (low bits of the 64-bit PC)
//  DATA_W   64  bus read data width; instruction is selected by pc[2]
// PORTS
//  clk               in   1       clock, all state on posedge
//  rst_n             in   1       asynchronous, active-low reset
//  IFfetch_pc        in   64      current PC from PC register
//  IFfetch_flush     in   1       redirect this cycle (WB trap/mret or ID jump/branch)
//  IFfetch_ID_ready  in   1       ID accepts an instruction this cycle
//  IFfetch_pc_enable out  1       PC register enable
//  IFfetch_valid     out  1       instruction/PC/fault valid to ID
//  IFfetch_inst      out  32      fetched instruction
//  IFfetch_inst_pc   out  64      PC of IFfetch_inst
//  IFfetch_fault     out  1       bus error on this fetch (inst forced 32'h0)
//  ar_valid / ar_ready  out/in  1    read-address handshake
//  ar_addr           out  ADDR_W  {IFfetch_pc[ADDR_W-1:2], 2'b00}
//  r_valid / r_ready    in/out  1    read-data handshake
//  r_data            in   DATA_W  read data
//  r_resp            in   2       2'b00 OKAY, else fault
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, drop=0, all outputs 0 (ar_valid, r_ready,
//   IFfetch_valid, pc_enable, inst, inst_pc, fault). In-flight bus beat abandoned;
//   interconnect shares the same reset.
//  FSM: IDLE -> AR (unconditional, next cycle). Latch req_pc = IFfetch_pc on IDLE->AR.
//   AR: ar_valid=1, ar_addr from req_pc, held stable until ar_ready. ar_ready -> R.
//   R: r_ready=1. On r_valid: drop=1 -> IDLE (beat discarded, drop cleared);
//      else capture inst = req_pc[2] ? r_data[63:32] : r_data[31:0],
//      inst_pc=req_pc, fault=(r_resp!=0), inst=0 if fault -> HOLD.
//   HOLD: IFfetch_valid=1, outputs stable. On ID_ready -> IDLE.
//  pc_enable = (HOLD & ID_ready & ~flush) | flush; combinational, one-cycle pulse.
//   The PC register updates on the same edge; the next AR uses the new PC
//   (fetch-to-fetch latency >= 4 cycles with zero-wait bus).
//  Flush rules:
//   IDLE: pc_enable=1; IDLE->AR still occurs, but req_pc is latched one cycle later
//         (stay IDLE one extra cycle) so the redirected PC is used.
//   AR / R: set drop=1; ar_valid never withdrawn; response discarded; then IDLE.
//   flush & r_valid same cycle in R: beat discarded, -> IDLE.
//   HOLD: IFfetch_valid drops next cycle, -> IDLE; a flush with ID_ready in the same
//         cycle takes priority, the handshake does not count (ID ignores it).
//  Never more than one outstanding AR. ar_valid and r_ready are never high together.
// STRUCTURE
//  State encodings (IDLE/AR/R/HOLD, 2 bits) and RESP_OKAY go in ysyx_041461_macro.v.
//  Single module; no sub-module. Word-select mux inline.
// TESTING
//  1 Reset release, pc=0x8000_0000, zero-wait bus, r_data=64'h0000_0297_0000_0413
//    -> ar_addr=0x8000_0000, inst=0x00000413, inst_pc=0x8000_0000, valid=1.
//  2 pc=0x8000_0004, same data -> inst=0x00000297 (upper word via pc[2]).
//  3 ID_ready=0 for 5 cycles in HOLD -> valid, inst, inst_pc stable; pc_enable=0;
//    no ar_valid.
//  4 Flush during R (r_valid delayed 3 cycles), PC redirected to 0x8000_0100
//    -> stale beat dropped, valid never rises for it, next ar_addr=0x8000_0100.
//  5 r_resp=2'b10 -> valid=1, fault=1, inst=0; ID_ready -> pc_enable pulse.
//  6 rst_n low while in AR with ar_ready=0 -> ar_valid=0 immediately (async),
//    state IDLE, all outputs 0.

Source files
------------

// File: rtl/ysyx_041461_if_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_041461_if_fetch_pkg
// Purpose : Shared types and constants for the instruction-fetch engine.
//           Holds the fetch FSM state encoding, the AXI OKAY response code
//           and the helper that picks one 32-bit instruction out of a
//           64-bit read beat.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package ysyx_041461_if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Word-aligned fetches live in either half of a 64-bit beat; pc[2] picks it.
  function automatic logic [31:0] select_word(input logic [63:0] i_data,
                                              input logic        i_upper);
    return i_upper ? i_data[63:32] : i_data[31:0];
  endfunction

endpackage

// File: rtl/ysyx_041461_if_fetch_if.sv
// ----------------------------------------------------------------------------
// ysyx_041461_if_fetch_if
// Purpose : AXI4-Lite style read channel (AR + R) between the fetch engine
//           and the instruction-memory interconnect.
// Ports   : none; signals
//   ar_valid / ar_ready  read-address handshake
//   ar_addr              word-aligned read address
//   r_valid  / r_ready   read-data handshake
//   r_data               read beat
//   r_resp               response code (OKAY or error)
// Modports: master (fetch side), slave (memory side)
// ----------------------------------------------------------------------------
interface ysyx_041461_if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();

  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  modport master (
    output ar_valid, ar_addr, r_ready,
    input  ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready,
    output ar_ready, r_valid, r_data, r_resp
  );

endinterface

// File: rtl/ysyx_041461_if_fetch.sv
// ----------------------------------------------------------------------------
// ysyx_041461_if_fetch
// Purpose : Instruction-fetch engine. Takes the PC from the PC register,
//           issues a single read per PC over the bus interface and presents
//           the 32-bit instruction to ID. Produces the PC-register enable so
//           the PC only advances (ID accepted) or redirects (flush) when this
//           block allows it. Only one request is ever in flight; a response
//           that belongs to a redirected-away PC is dropped.
// Ports   :
//   clk, rst_n          clock, asynchronous active-low reset
//   IFfetch_pc          current PC from the PC register
//   IFfetch_flush       redirect this cycle
//   IFfetch_ID_ready    ID accepts the presented instruction
//   IFfetch_pc_enable   PC register enable (one-cycle pulse)
//   IFfetch_valid       instruction / PC / fault valid to ID
//   IFfetch_inst        fetched instruction (0 on fault)
//   IFfetch_inst_pc     PC of IFfetch_inst
//   IFfetch_fault       bus error on this fetch
//   bus                 read channel, master side
// ----------------------------------------------------------------------------
module ysyx_041461_if_fetch
  import ysyx_041461_if_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [63:0]                    IFfetch_pc,
  input  logic                           IFfetch_flush,
  input  logic                           IFfetch_ID_ready,
  output logic                           IFfetch_pc_enable,
  output logic                           IFfetch_valid,
  output logic [31:0]                    IFfetch_inst,
  output logic [63:0]                    IFfetch_inst_pc,
  output logic                           IFfetch_fault,
  ysyx_041461_if_fetch_if.master         bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic         r_drop;
  logic         w_drop_next;
  logic [63:0]  r_req_pc;
  logic [31:0]  r_inst;
  logic [63:0]  r_inst_pc;
  logic         r_fault;
  logic         w_latch_req;
  logic         w_capture;
  logic         w_resp_fault;

  assign w_resp_fault = (bus.r_resp != RESP_OKAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
    end
  end

  // A flush seen while idle delays the PC latch by one cycle, because the PC
  // register is being redirected on that same edge. A flush in AR/R cannot
  // withdraw the bus request, so it just marks the coming beat for dropping.
  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    w_latch_req  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!IFfetch_flush) begin
          w_latch_req  = 1'b1;
          w_state_next = ST_AR;
        end
      end
      ST_AR: begin
        if (IFfetch_flush) w_drop_next = 1'b1;
        if (bus.ar_ready) w_state_next = ST_R;
      end
      ST_R: begin
        if (bus.r_valid) begin
          if (r_drop || IFfetch_flush) begin
            w_drop_next  = 1'b0;
            w_state_next = ST_IDLE;
          end else begin
            w_capture    = 1'b1;
            w_state_next = ST_HOLD;
          end
        end else if (IFfetch_flush) begin
          w_drop_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (IFfetch_flush || IFfetch_ID_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_pc  <= 64'h0;
      r_inst    <= 32'h0;
      r_inst_pc <= 64'h0;
      r_fault   <= 1'b0;
    end else begin
      if (w_latch_req) r_req_pc <= IFfetch_pc;
      if (w_capture) begin
        r_inst    <= w_resp_fault ? 32'h0 : select_word(bus.r_data, r_req_pc[2]);
        r_inst_pc <= r_req_pc;
        r_fault   <= w_resp_fault;
      end
    end
  end

  assign bus.ar_valid = (r_state == ST_AR);
  assign bus.ar_addr  = {r_req_pc[ADDR_W-1:2], 2'b00};
  assign bus.r_ready  = (r_state == ST_R);

  assign IFfetch_valid   = (r_state == ST_HOLD);
  assign IFfetch_inst    = r_inst;
  assign IFfetch_inst_pc = r_inst_pc;
  assign IFfetch_fault   = r_fault;

  // A flush alongside ID_ready wins, so the handshake is not an accept; the
  // reset term keeps the enable low while the block is held in reset.
  assign IFfetch_pc_enable = rst_n &
    (((r_state == ST_HOLD) & IFfetch_ID_ready & ~IFfetch_flush) | IFfetch_flush);

endmodule

// File: tb/tb_ysyx_041461_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_ysyx_041461_if_fetch
// Purpose : Randomized scoreboard bench for the instruction-fetch engine.
//           The bench plays the PC register, ID stage and instruction memory.
// ----------------------------------------------------------------------------
module tb_ysyx_041461_if_fetch;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_exp_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] IFfetch_pc;
  logic        IFfetch_flush;
  logic        IFfetch_ID_ready;
  logic        IFfetch_pc_enable;
  logic        IFfetch_valid;
  logic [31:0] IFfetch_inst;
  logic [63:0] IFfetch_inst_pc;
  logic        IFfetch_fault;

  ysyx_041461_if_fetch_if #(.ADDR_W(32), .DATA_W(64)) busIf ();

  ysyx_041461_if_fetch #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .IFfetch_pc        (IFfetch_pc),
    .IFfetch_flush     (IFfetch_flush),
    .IFfetch_ID_ready  (IFfetch_ID_ready),
    .IFfetch_pc_enable (IFfetch_pc_enable),
    .IFfetch_valid     (IFfetch_valid),
    .IFfetch_inst      (IFfetch_inst),
    .IFfetch_inst_pc   (IFfetch_inst_pc),
    .IFfetch_fault     (IFfetch_fault),
    .bus               (busIf)
  );

  int          errors = 0;
  int          checks = 0;
  int          cycleCount = 0;
  int          lastAcceptCycle = 0;
  int          faultAccepts = 0;
  int          arCount = 0;
  fetch_exp_t  expQ[$];
  logic [63:0] pcReg;
  logic [63:0] flushTarget;
  logic [63:0] reqTarget;
  logic        flushReq = 1'b0;
  logic        randomMode = 1'b0;
  int          fixedDelay = 0;
  logic        idReadyForce = 1'b1;
  logic        arStall = 1'b0;
  logic        outstanding = 1'b0;
  int          delay = 0;
  logic [31:0] beatAddr = 32'h0;
  logic        checkNextAr = 1'b0;
  logic [31:0] expectAr = 32'h0;
  logic        sawRReady;
  logic        sawArValid;
  logic        monitorOn = 1'b0;

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: the beat at the boot address is the known pattern,
  // every other beat is derived from its address so each word is distinct.
  function automatic logic [63:0] beatData(input logic [31:0] addr);
    if (addr == 32'h8000_0000) return 64'h0000_0297_0000_0413;
    return {addr ^ 32'hdead_beef, ~addr};
  endfunction

  // Beats whose address bits [6:3] are 4'hb answer with a bus error.
  function automatic logic faultAt(input logic [31:0] addr);
    return (addr[6:3] == 4'hb);
  endfunction

  // What ID must see for a given PC: the half of the aligned beat chosen by
  // pc[2], or zero with the fault flag if that beat errors.
  function automatic fetch_exp_t expectedFor(input logic [63:0] pc);
    fetch_exp_t  e;
    logic [31:0] base;
    logic [63:0] d;
    base    = {pc[31:3], 3'b000};
    d       = beatData(base);
    e.pc    = pc;
    e.fault = faultAt(base);
    if (e.fault)    e.inst = 32'h0;
    else if (pc[2]) e.inst = d[63:32];
    else            e.inst = d[31:0];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic printSummary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".ar_valid"}, busIf.ar_valid, 0);
    checkOutput({tag, ".r_ready"}, busIf.r_ready, 0);
    checkOutput({tag, ".valid"}, IFfetch_valid, 0);
    checkOutput({tag, ".pc_enable"}, IFfetch_pc_enable, 0);
    checkOutput({tag, ".inst"}, IFfetch_inst, 0);
    checkOutput({tag, ".inst_pc"}, IFfetch_inst_pc, 0);
    checkOutput({tag, ".fault"}, IFfetch_fault, 0);
  endtask

  // One clock of environment: sample handshakes at the negedge, then after
  // the posedge update the PC register, the memory slave and the scoreboard,
  // and drive fresh inputs for the next cycle.
  task automatic applyStimulus();
    logic        arFire, rFire, pcEn, fl;
    logic [31:0] arAddr;
    logic [63:0] tgt, t;
    @(negedge clk);
    arFire     = busIf.ar_valid && busIf.ar_ready;
    rFire      = busIf.r_valid && busIf.r_ready;
    arAddr     = busIf.ar_addr;
    pcEn       = IFfetch_pc_enable;
    fl         = IFfetch_flush;
    tgt        = flushTarget;
    sawRReady  = busIf.r_ready;
    sawArValid = busIf.ar_valid;
    @(posedge clk);
    #1;
    cycleCount++;
    if (rFire) outstanding = 1'b0;
    if (arFire) begin
      checkOutput("singleOutstanding", outstanding, 0);
      checkOutput("arAddrAligned", arAddr[1:0], 0);
      if (arCount == 0) checkOutput("firstArAddr", arAddr, 32'h8000_0000);
      if (checkNextAr) begin
        checkOutput("redirectArAddr", arAddr, expectAr);
        checkNextAr = 1'b0;
      end
      arCount++;
      outstanding = 1'b1;
      beatAddr    = {arAddr[31:3], 3'b000};
      delay       = randomMode ? int'($urandom_range(0, 3)) : fixedDelay;
    end
    if (pcEn) begin
      pcReg = fl ? tgt : pcReg + 64'd4;
      if (fl) expQ.delete();
      expQ.push_back(expectedFor(pcReg));
    end
    IFfetch_pc = pcReg;
    busIf.r_valid = outstanding && (delay == 0);
    if (outstanding && delay != 0) delay--;
    busIf.r_data = beatData(beatAddr);
    busIf.r_resp = faultAt(beatAddr) ? 2'b10 : 2'b00;
    busIf.ar_ready = arStall ? 1'b0 : (randomMode ? ($urandom_range(0, 2) != 0) : 1'b1);
    IFfetch_ID_ready = randomMode ? ($urandom_range(0, 3) != 0) : idReadyForce;
    if (flushReq) begin
      IFfetch_flush = 1'b1;
      flushTarget   = reqTarget;
      flushReq      = 1'b0;
    end else if (randomMode && $urandom_range(0, 9) == 0) begin
      t = 64'h8000_0000 | (64'($urandom_range(0, 1023)) << 2);
      if (t == pcReg) t = t + 64'd4;
      IFfetch_flush = 1'b1;
      flushTarget   = t;
    end else begin
      IFfetch_flush = 1'b0;
    end
    if (cycleCount - lastAcceptCycle > 300) begin
      errors++;
      checks++;
      $display("[TB] FAIL fetchTimeout: no accepted instruction for %0d cycles, want <= 300",
               cycleCount - lastAcceptCycle);
      printSummary();
      $finish;
    end
  endtask

  // Monitor: checks every cycle's bus rules and PC-enable, and pops the
  // scoreboard whenever ID really accepts an instruction.
  always @(negedge clk) begin : monitor
    logic        accept;
    fetch_exp_t  e;
    static logic        prevArWait = 1'b0;
    static logic [31:0] prevArAddr = 32'h0;
    static logic        prevHold   = 1'b0;
    static logic [31:0] prevInst   = 32'h0;
    static logic [63:0] prevInstPc = 64'h0;
    static logic        prevFault  = 1'b0;
    if (rst_n && monitorOn) begin
      accept = IFfetch_valid && IFfetch_ID_ready && !IFfetch_flush;
      checkOutput("pcEnable", IFfetch_pc_enable,
                  IFfetch_flush || (IFfetch_valid && IFfetch_ID_ready));
      checkOutput("busExclusive", busIf.ar_valid && busIf.r_ready, 0);
      if (IFfetch_valid) checkOutput("noArWhileValid", busIf.ar_valid, 0);
      if (prevArWait) begin
        checkOutput("arHeld", busIf.ar_valid, 1);
        checkOutput("arAddrStable", busIf.ar_addr, prevArAddr);
      end
      if (prevHold) begin
        checkOutput("holdValid", IFfetch_valid, 1);
        checkOutput("holdInst", IFfetch_inst, prevInst);
        checkOutput("holdInstPc", IFfetch_inst_pc, prevInstPc);
        checkOutput("holdFault", IFfetch_fault, prevFault);
      end
      if (accept) begin
        if (expQ.size() == 0) begin
          errors++;
          checks++;
          $display("[TB] FAIL unexpectedValid: got inst_pc %h, want no instruction",
                   IFfetch_inst_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("instPc", IFfetch_inst_pc, e.pc);
          checkOutput("inst", IFfetch_inst, 64'(e.inst));
          checkOutput("fault", IFfetch_fault, 64'(e.fault));
        end
        if (IFfetch_fault) faultAccepts++;
        lastAcceptCycle = cycleCount;
      end
      prevArWait = busIf.ar_valid && !busIf.ar_ready;
      prevArAddr = busIf.ar_addr;
      prevHold   = IFfetch_valid && !IFfetch_ID_ready && !IFfetch_flush;
      prevInst   = IFfetch_inst;
      prevInstPc = IFfetch_inst_pc;
      prevFault  = IFfetch_fault;
    end
  end

  initial begin
    logic found;
    rst_n            = 1'b0;
    pcReg            = 64'h8000_0000;
    flushTarget      = 64'h0;
    reqTarget        = 64'h0;
    IFfetch_pc       = pcReg;
    IFfetch_flush    = 1'b0;
    IFfetch_ID_ready = 1'b1;
    busIf.ar_ready   = 1'b1;
    busIf.r_valid    = 1'b0;
    busIf.r_data     = 64'h0;
    busIf.r_resp     = 2'b00;
    expQ.push_back(expectedFor(pcReg));
    repeat (3) @(posedge clk);
    #2;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    monitorOn = 1'b1;

    // Zero-wait bus, ID always ready: boot word then the upper half.
    randomMode = 1'b0; fixedDelay = 0; idReadyForce = 1'b1;
    repeat (12) applyStimulus();

    // ID stalls while an instruction is held.
    idReadyForce = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("stallHoldsValid", IFfetch_valid, 1);
    checkOutput("stallNoPcEnable", IFfetch_pc_enable, 0);
    idReadyForce = 1'b1;
    repeat (4) applyStimulus();

    // Redirect while the read beat is delayed three cycles.
    fixedDelay = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus();
      if (sawRReady) found = 1'b1;
    end
    checkOutput("reachedReadPhase", found, 1);
    reqTarget   = 64'h8000_0100;
    flushReq    = 1'b1;
    checkNextAr = 1'b1;
    expectAr    = 32'h8000_0100;
    repeat (15) applyStimulus();
    checkOutput("redirectArSeen", checkNextAr, 0);

    // Redirect onto an erroring beat.
    fixedDelay = 0;
    reqTarget  = 64'h8000_0058;
    flushReq   = 1'b1;
    repeat (12) applyStimulus();
    checkOutput("faultDelivered", faultAccepts != 0, 1);

    // Randomized traffic.
    randomMode = 1'b1;
    repeat (1500) applyStimulus();

    // Asynchronous reset while a request waits in AR.
    randomMode = 1'b0; idReadyForce = 1'b1; arStall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus();
      if (sawArValid) found = 1'b1;
    end
    checkOutput("reachedAddrPhase", found, 1);
    checkOutput("arValidBeforeReset", busIf.ar_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("asyncReset");
    @(posedge clk);
    #1;
    checkResetOutputs("heldReset");
    printSummary();
    $finish;
  end

endmodule
